// File: rtl/bin_stream_pkg.sv
// Shared types and helpers for the bin-averaging stream path.
package bin_stream_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } unpack_state_t;

  localparam int FRAME_CNT_W = 16;

  // Number of narrow transport words that make up one frame of bin sums.
  function automatic int words_per_frame(input int bw, input int n_prl, input int bw_out);
    return (bw * n_prl) / bw_out;
  endfunction

endpackage

// File: rtl/bin_frame_unpack.sv
// Reassembles narrow transport words into a full frame of bin sums and
// presents it downstream with a valid/ready handshake. Runt frames are
// dropped and reported; a fresh start-of-frame always resynchronises.
module bin_frame_unpack
  import bin_stream_pkg::*;
#(
  parameter int BW     = 32,
  parameter int N_PRL  = 4,
  parameter int BW_out = 8
) (
  input  logic                          clk,
  input  logic                          arest,
  input  logic                          in_valid,
  input  logic                          in_sof,
  input  logic [BW_out-1:0]             in_data,
  output logic                          in_ready,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [N_PRL-1:0][BW-1:0]      y,
  output logic                          frame_err,
  output logic [FRAME_CNT_W-1:0]        frame_cnt
);

  localparam int TOT   = BW * N_PRL;
  localparam int WORDS = words_per_frame(BW, N_PRL, BW_out);
  localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORDS - 1);

  if ((BW * N_PRL) % BW_out != 0) begin : g_width_check
    $error("bin_frame_unpack: BW*N_PRL must be a multiple of BW_out");
  end

  unpack_state_t    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] wr_idx;
  logic [TOT-1:0]   asm_q, asm_d;
  logic             accept, handshake, store, load_y, err_d;

  assign in_ready  = (state_q != HOLD);
  assign out_valid = (state_q == HOLD);
  assign accept    = in_valid && in_ready;
  assign handshake = out_valid && out_ready;

  // Next-state logic: decides where each accepted word lands and when the frame is complete.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_idx  = '0;
    store   = 1'b0;
    load_y  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept && in_sof) begin
          store = 1'b1;
          if (WORDS == 1) begin
            state_d = HOLD;
            load_y  = 1'b1;
            cnt_d   = '0;
          end else begin
            state_d = FILL;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      FILL: begin
        if (accept) begin
          store = 1'b1;
          if (in_sof) begin
            err_d = 1'b1;
            cnt_d = CNT_W'(1);
          end else begin
            wr_idx = cnt_q;
            if (cnt_q == LAST_IDX) begin
              state_d = HOLD;
              load_y  = 1'b1;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Assembly image including the word being accepted this cycle, so the final word reaches y directly.
  always_comb begin
    asm_d = asm_q;
    if (store) asm_d[TOT-1 - int'(wr_idx)*BW_out -: BW_out] = in_data;
  end

  // State, assembly, output frame and status registers.
  always_ff @(posedge clk or posedge arest) begin
    if (arest) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      asm_q     <= '0;
      y         <= '0;
      frame_err <= 1'b0;
      frame_cnt <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      asm_q     <= asm_d;
      frame_err <= err_d;
      if (load_y) begin
        for (int i = 0; i < N_PRL; i++) begin
          y[i] <= asm_d[TOT-1 - i*BW -: BW];
        end
      end
      if (handshake) frame_cnt <= frame_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_bin_frame_unpack.sv
// Directed bench for bin_frame_unpack at default parameters.
module tb_bin_frame_unpack;

  localparam int BW     = 32;
  localparam int N_PRL  = 4;
  localparam int BW_OUT = 8;
  localparam int WORDS  = 16;

  logic                     clk;
  logic                     arest;
  logic                     in_valid;
  logic                     in_sof;
  logic [BW_OUT-1:0]        in_data;
  logic                     in_ready;
  logic                     out_valid;
  logic                     out_ready;
  logic [N_PRL-1:0][BW-1:0] y;
  logic                     frame_err;
  logic [15:0]              frame_cnt;

  int assert_cnt = 0;
  int fail_cnt   = 0;
  int err_seen;
  logic hold_ok;
  logic [N_PRL-1:0][BW-1:0] y_snap;

  bin_frame_unpack #(
    .BW     (BW),
    .N_PRL  (N_PRL),
    .BW_out (BW_OUT)
  ) dut (
    .clk       (clk),
    .arest     (arest),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .frame_err (frame_err),
    .frame_cnt (frame_cnt)
  );

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    assert_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends n back-to-back words base, base+1, ... with sof on the first word.
  task automatic apply_stimulus(input logic [7:0] base, input int n);
    for (int k = 0; k < n; k++) begin
      in_valid = 1'b1;
      in_sof   = (k == 0);
      in_data  = base + 8'(k);
      tick();
      if (n == WORDS && k == n - 2) check_output("early_valid", out_valid, 0);
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  // Directed test sequence.
  initial begin
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    arest     = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_output("reset_valid", out_valid, 0);
    check_output("reset_err", frame_err, 0);
    check_output("reset_cnt", frame_cnt, 0);
    check_output("reset_y", y, 0);
    arest = 1'b0;
    tick();
    check_output("reset_ready", in_ready, 1);

    // Basic frame 0x00..0x0F.
    apply_stimulus(8'h00, 16);
    check_output("t1_valid", out_valid, 1);
    check_output("t1_ready", in_ready, 0);
    check_output("t1_y0", y[0], 128'h00010203);
    check_output("t1_y3", y[3], 128'h0C0D0E0F);
    check_output("t1_cnt_pre", frame_cnt, 0);
    tick();
    check_output("t1_valid_drop", out_valid, 0);
    check_output("t1_cnt", frame_cnt, 1);
    check_output("t1_ready_back", in_ready, 1);

    // Stray words before sof are dropped.
    in_valid = 1'b1; in_sof = 1'b0; in_data = 8'hAA; tick();
    in_data = 8'hBB; tick();
    in_valid = 1'b0; tick();
    check_output("t2_valid", out_valid, 0);
    check_output("t2_err", frame_err, 0);
    apply_stimulus(8'h40, 16);
    check_output("t2_y0", y[0], 128'h40414243);
    check_output("t2_y2", y[2], 128'h48494A4B);
    tick();
    check_output("t2_cnt", frame_cnt, 2);

    // Runt frame of 5 words followed by a full frame.
    apply_stimulus(8'h80, 5);
    check_output("t3_no_err_yet", frame_err, 0);
    err_seen = 0;
    for (int k = 0; k < WORDS; k++) begin
      in_valid = 1'b1;
      in_sof   = (k == 0);
      in_data  = 8'h20 + 8'(k);
      tick();
      if (frame_err) err_seen++;
      if (k == 0) check_output("t3_err_pulse", frame_err, 1);
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
    check_output("t3_err_count", err_seen, 1);
    check_output("t3_valid", out_valid, 1);
    check_output("t3_y0", y[0], 128'h20212223);
    check_output("t3_y3", y[3], 128'h2C2D2E2F);
    tick();
    check_output("t3_cnt", frame_cnt, 3);

    // Backpressure: out_ready low for 20 cycles with input words offered.
    out_ready = 1'b0;
    apply_stimulus(8'h60, 16);
    hold_ok = 1'b1;
    y_snap  = y;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_sof   = (i % 2 == 0);
      in_data  = 8'hFF;
      tick();
      if (!out_valid || in_ready || (y !== y_snap)) hold_ok = 1'b0;
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
    check_output("t4_hold", hold_ok, 1);
    check_output("t4_y1", y[1], 128'h64656667);
    check_output("t4_cnt_pre", frame_cnt, 3);
    out_ready = 1'b1;
    tick();
    check_output("t4_valid", out_valid, 0);
    check_output("t4_ready", in_ready, 1);
    check_output("t4_cnt", frame_cnt, 4);
    tick();
    check_output("t4_idle", out_valid, 0);

    // Asynchronous reset in the middle of a frame.
    apply_stimulus(8'h30, 10);
    #2;
    arest = 1'b1;
    #1;
    check_output("t5_valid", out_valid, 0);
    check_output("t5_err", frame_err, 0);
    check_output("t5_cnt", frame_cnt, 0);
    check_output("t5_y", y, 0);
    @(posedge clk);
    #1;
    arest = 1'b0;
    tick();
    apply_stimulus(8'h90, 16);
    check_output("t5_y0", y[0], 128'h90919293);
    check_output("t5_y3", y[3], 128'h9C9D9E9F);
    check_output("t5_err_after", frame_err, 0);
    tick();
    check_output("t5_cnt_after", frame_cnt, 1);

    // Frame counter wrap from 0xFFFF.
    force dut.frame_cnt = 16'hFFFF;
    #1;
    release dut.frame_cnt;
    #1;
    check_output("t6_preload", frame_cnt, 16'hFFFF);
    apply_stimulus(8'hA0, 16);
    check_output("t6_valid", out_valid, 1);
    check_output("t6_y2", y[2], 128'hA8A9AAAB);
    tick();
    check_output("t6_wrap", frame_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/bin_frame_unpack.md
# bin_frame_unpack

Receive-side counterpart of the bin-averaging output path. Accepts the narrow word stream produced for Ethernet transport (BW_out bits per word, frame start flagged by `in_sof`) and reassembles each frame into an N_PRL × BW-bit vector of averaged bin sums. The output uses a valid/ready handshake toward downstream spectrum consumers. Runt frames are detected, reported, and resynchronised on the next start-of-frame.

## Interface
- `BW`, 32, width of one bin sum (SUM_WIDTH on the transmit side)
- `N_PRL`, 4, bins per frame
- `BW_out`, 8, input word width; `BW*N_PRL` must be a multiple of `BW_out`
- Derived: `WORDS = BW*N_PRL/BW_out` (16 at defaults)

Ports:
- `clk`  in  1  sole clock
- `arest`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  input word valid
- `in_sof`  in  1  current word is word 0 of a frame
- `in_data`  in  BW_out  input word
- `in_ready`  out  1  block can accept a word
- `out_valid`  out  1  `y` holds a complete frame
- `out_ready`  in  1  downstream accepts `y`
- `y`  out  [N_PRL-1:0][BW-1:0]  reassembled bin sums
- `frame_err`  out  1  one-cycle pulse: runt frame discarded
- `frame_cnt`  out  16  frames delivered, wraps 0xFFFF→0

## Operation
- Word accept: `in_valid && in_ready`.
- Word order: word k fills bits `[BW*N_PRL-1 - k*BW_out -: BW_out]` of the concatenation `{y[0], y[1], ..., y[N_PRL-1]}`. Bin 0 comes first, MSB-first within each bin.
- FSM states:
  - IDLE: `in_ready=1`. Accepted words with `in_sof=0` are dropped silently. An accepted word with `in_sof=1` becomes word 0; `cnt←1`; go to FILL.
  - FILL: `in_ready=1`. An accepted word with `in_sof=1` means a runt frame: pulse `frame_err`, discard the partial frame, store this word as word 0, set `cnt←1`, and stay in FILL. An accepted word with `in_sof=0` is stored at `cnt`. If `cnt==WORDS-1`, go to HOLD; otherwise `cnt++`.
  - HOLD: `in_ready=0`, `out_valid=1`. On `out_ready`, `frame_cnt++` and go to IDLE.
- `y` is loaded from the assembly register on the FILL→HOLD transition only. It holds its value outside HOLD, so a partial frame is never visible.
- `in_sof` arriving on the final word position (`cnt==WORDS-1`) is treated as a runt, not as a completion.
- `cnt` width is `$clog2(WORDS)`. There is no overflow path, since FILL exits at `WORDS-1`.
- `WORDS==1` is legal: a single `sof` word in IDLE goes directly to HOLD.

## Timing
- Reset values: state IDLE, `cnt=0`, `y=0`, `out_valid=0`, `frame_err=0`, `frame_cnt=0`. `in_ready` is 1 one cycle after reset deassertion and is combinational from state.
- Latency: `out_valid` rises the cycle after the last word is accepted.
- `in_ready` falls in the same cycle that `out_valid` rises.
- The HOLD→IDLE transition costs one bubble. Minimum frame period is `WORDS+1` cycles when `out_ready` is held high.
- `frame_err` is registered and asserts the cycle after the offending `sof` word is accepted.
- `frame_cnt` updates the cycle after the `out_valid && out_ready` handshake.
- Gaps in `in_valid` stall assembly without limit. There is no timeout.
- `arest` mid-frame: the partial frame and any pending `y` are discarded, and all outputs return to reset values asynchronously.

## Structure
- Shared package `bin_stream_pkg`:
  - state enum `unpack_state_t` {IDLE, FILL, HOLD}
  - function `words_per_frame(bw, n_prl, bw_out)`
  - frame-count width constant `FRAME_CNT_W=16`
- No sub-module. The design is a single FSM plus an assembly shift/index register.
- Elaboration-time `$error` if `BW*N_PRL % BW_out != 0`.

## Test plan
- Defaults, one frame of 16 words 0x00..0x0F with `sof` on word 0, `out_ready=1` → `y[0]=0x00010203`, `y[3]=0x0C0D0E0F`, `out_valid` pulses 1 cycle, `frame_cnt=1`.
- Words 0xAA, 0xBB with `in_sof=0` before any `sof` → dropped, no `out_valid`, no `frame_err`; the subsequent good frame is delivered correctly.
- `sof` frame truncated after 5 words, then a new `sof` frame of 16 words → `frame_err` single pulse, the second frame is delivered intact, `frame_cnt=1`.
- `out_ready=0` for 20 cycles after completion → `out_valid` held, `in_ready=0`, `y` stable, input words ignored. Release → handshake occurs and `in_ready` returns the next cycle.
- Assert `arest` after word 9 of a frame → all outputs zero. The next full frame is delivered with `frame_cnt=1`.
- Preload 65535 frames (or force `frame_cnt`), deliver one more → `frame_cnt` wraps to 0.
